// File: rtl/branch_predictor_btb.sv
// Branch target buffer with a per-entry valid bit and a 2-bit saturating counter.
// The lookup is combinational from PC. It is trained through a one-cycle update
// port, and flush_all invalidates every entry synchronously.
// Optional: define BP_STATS_EN to add the stat_lookups and stat_mispredicts
// counters and the update_mispredict input.
module branch_predictor_btb #(
  parameter int unsigned WORD_SIZE  = 16,
  parameter int unsigned INDEX_BITS = 8,
  parameter int unsigned TAG_BITS   = 8,
  parameter logic [1:0]  CTR_INIT   = 2'b01
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] next_PC,
  output logic                 pred_hit,
  output logic                 pred_taken,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 flush_all
`ifdef BP_STATS_EN
  ,
  input  logic                 update_mispredict,
  output logic [31:0]          stat_lookups,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  logic                 valid_q  [DEPTH];
  logic                 valid_d  [DEPTH];
  logic [1:0]           ctr_q    [DEPTH];
  logic [1:0]           ctr_d    [DEPTH];
  logic [TAG_BITS-1:0]  tag_q    [DEPTH];
  logic [TAG_BITS-1:0]  tag_d    [DEPTH];
  logic [WORD_SIZE-1:0] target_q [DEPTH];
  logic [WORD_SIZE-1:0] target_d [DEPTH];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   ptag;
  logic [INDEX_BITS-1:0] uidx;
  logic [TAG_BITS-1:0]   utag;
  logic                  uhit;

  // Lookup: predict next fetch PC from the current (pre-update) table contents
  always_comb begin
    idx        = PC[INDEX_BITS-1:0];
    ptag       = PC[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
    pred_hit   = valid_q[idx] && (tag_q[idx] == ptag);
    pred_taken = pred_hit && ctr_q[idx][1];
    next_PC    = pred_taken ? target_q[idx] : PC + WORD_SIZE'(1);
  end

  // Training: flush beats update; hits move the counter, taken misses allocate
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    uidx     = update_pc[INDEX_BITS-1:0];
    utag     = update_pc[INDEX_BITS+TAG_BITS-1:INDEX_BITS];
    uhit     = valid_q[uidx] && (tag_q[uidx] == utag);
    if (flush_all) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_d[i] = 1'b0;
        ctr_d[i]   = CTR_INIT;
      end
    end else if (update_valid) begin
      if (uhit) begin
        if (update_taken) begin
          ctr_d[uidx]    = (ctr_q[uidx] == 2'b11) ? 2'b11 : ctr_q[uidx] + 2'b01;
          target_d[uidx] = update_target;
        end else begin
          ctr_d[uidx] = (ctr_q[uidx] == 2'b00) ? 2'b00 : ctr_q[uidx] - 2'b01;
        end
      end else if (update_taken) begin
        valid_d[uidx]  = 1'b1;
        tag_d[uidx]    = utag;
        target_d[uidx] = update_target;
        ctr_d[uidx]    = 2'b10;
      end
    end
  end

  // Valid bits and counters carry the reset state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tag and target storage is not reset; valid gates every use of it
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_lookups_q, stat_lookups_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  // Event counters, free-running modulo 2^32
  always_comb begin
    stat_lookups_d     = stat_lookups_q + {31'b0, pred_hit};
    stat_mispredicts_d = stat_mispredicts_q + {31'b0, update_valid & update_mispredict};
  end

  // Counter registers; cleared only by reset, never by flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_lookups_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_lookups_q     <= stat_lookups_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_lookups     = stat_lookups_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: a directed vector table,
// hand-written reset and stats sequences, and randomized traffic compared
// against an array-based reference model.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] PC;
  logic [15:0] next_PC;
  logic        pred_hit;
  logic        pred_taken;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic        flush_all;
  logic        update_mispredict;
`ifdef BP_STATS_EN
  logic [31:0] stat_lookups;
  logic [31:0] stat_mispredicts;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(
    .WORD_SIZE (16),
    .INDEX_BITS(8),
    .TAG_BITS  (8),
    .CTR_INIT  (2'b01)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .PC           (PC),
    .next_PC      (next_PC),
    .pred_hit     (pred_hit),
    .pred_taken   (pred_taken),
    .update_valid (update_valid),
    .update_pc    (update_pc),
    .update_taken (update_taken),
    .update_target(update_target),
    .flush_all    (flush_all)
`ifdef BP_STATS_EN
    ,
    .update_mispredict(update_mispredict),
    .stat_lookups     (stat_lookups),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Reference model: one record per index, using plain integer arithmetic.
  bit          m_valid [256];
  int          m_tag   [256];
  int          m_tgt   [256];
  int          m_ctr   [256];
  int unsigned m_lookups;
  int unsigned m_misp;

  function automatic void m_reset();
    for (int i = 0; i < 256; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_lookups = 0;
    m_misp    = 0;
  endfunction

  function automatic void m_lookup(input int pc, output bit hit, output bit tk, output int nxt);
    int i;
    i   = pc % 256;
    hit = m_valid[i] && (m_tag[i] == pc / 256);
    tk  = hit && (m_ctr[i] >= 2);
    nxt = tk ? m_tgt[i] : (pc + 1) % 65536;
  endfunction

  function automatic void m_train(input bit uv, input int upc, input bit ut, input int utgt, input bit fl);
    int i;
    bit hit;
    i   = upc % 256;
    hit = m_valid[i] && (m_tag[i] == upc / 256);
    if (fl) begin
      for (int k = 0; k < 256; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (uv) begin
      if (hit && ut) begin
        m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = utgt;
      end else if (hit) begin
        m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
      end else if (ut) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = upc / 256;
        m_tgt[i]   = utgt;
        m_ctr[i]   = 2;
      end
    end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check lookup before the edge, clock, advance model.
  task automatic run_cycle(input logic [15:0] pc, input bit uv, input logic [15:0] upc,
                           input bit ut, input logic [15:0] utgt, input bit fl, input bit mis,
                           input bit use_exp, input bit eh, input bit et, input logic [15:0] en,
                           input string nm);
    bit mh, mt;
    int mn;
    PC = pc; update_valid = uv; update_pc = upc; update_taken = ut;
    update_target = utgt; flush_all = fl; update_mispredict = mis;
    #1;
    m_lookup(int'(pc), mh, mt, mn);
    if (!use_exp) begin
      eh = mh; et = mt; en = 16'(mn);
    end
    chk({nm, ".hit"},   longint'(pred_hit),   longint'(eh));
    chk({nm, ".taken"}, longint'(pred_taken), longint'(et));
    chk({nm, ".next"},  longint'(next_PC),    longint'(en));
    if (mh) m_lookups++;
    if (uv && mis) m_misp++;
    m_train(uv, int'(upc), ut, int'(utgt), fl);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    update_valid = 1'b0; flush_all = 1'b0; update_mispredict = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
  endtask

  typedef struct {
    logic [15:0] pc;
    bit          uv;
    logic [15:0] upc;
    bit          ut;
    logic [15:0] utgt;
    bit          fl;
    bit          eh;
    bit          et;
    logic [15:0] en;
  } vec_t;

  vec_t tbl [25];

  function automatic vec_t mk(input logic [15:0] pc, input bit uv, input logic [15:0] upc,
                              input bit ut, input logic [15:0] utgt, input bit fl,
                              input bit eh, input bit et, input logic [15:0] en);
    vec_t v;
    v.pc = pc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.fl = fl;
    v.eh = eh; v.et = et; v.en = en;
    return v;
  endfunction

  initial begin
    bit          rh, rt;
    int          rn;
    logic [15:0] rpc, rupc;

    // Directed sequence: expected outputs are sampled before the row's clock edge.
    tbl[0]  = mk(16'h0123, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0124);
    tbl[1]  = mk(16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000);
    tbl[2]  = mk(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 0, 0, 16'h0124);
    tbl[3]  = mk(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 1, 1, 16'h0200);
    tbl[4]  = mk(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 1, 1, 16'h0200);
    tbl[5]  = mk(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 1, 1, 16'h0200);
    tbl[6]  = mk(16'h0123, 1, 16'h0123, 0, 16'h0000, 0, 1, 1, 16'h0200);
    tbl[7]  = mk(16'h0123, 1, 16'h0123, 0, 16'h0000, 0, 1, 1, 16'h0200);
    tbl[8]  = mk(16'h0123, 1, 16'h0123, 0, 16'h0000, 0, 1, 0, 16'h0124);
    tbl[9]  = mk(16'h0123, 1, 16'h0123, 0, 16'h0000, 0, 1, 0, 16'h0124);
    tbl[10] = mk(16'h0123, 1, 16'h0123, 1, 16'h0250, 0, 1, 0, 16'h0124);
    tbl[11] = mk(16'h0123, 1, 16'h0123, 1, 16'h0260, 0, 1, 0, 16'h0124);
    tbl[12] = mk(16'h0123, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0260);
    tbl[13] = mk(16'h0123, 1, 16'h0523, 1, 16'h0300, 0, 1, 1, 16'h0260);
    tbl[14] = mk(16'h0123, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0124);
    tbl[15] = mk(16'h0523, 1, 16'h0723, 0, 16'h0400, 0, 1, 1, 16'h0300);
    tbl[16] = mk(16'h0523, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0300);
    tbl[17] = mk(16'h0723, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0724);
    tbl[18] = mk(16'h0523, 0, 16'h0523, 1, 16'h0999, 0, 1, 1, 16'h0300);
    tbl[19] = mk(16'h0523, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0300);
    tbl[20] = mk(16'h0040, 1, 16'h0040, 1, 16'h0111, 1, 0, 0, 16'h0041);
    tbl[21] = mk(16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0041);
    tbl[22] = mk(16'h0523, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0524);
    tbl[23] = mk(16'h0040, 1, 16'h0040, 1, 16'h0111, 0, 0, 0, 16'h0041);
    tbl[24] = mk(16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 1, 1, 16'h0111);

    PC = 16'h0123; update_pc = '0; update_taken = 1'b0; update_target = '0;
    update_valid = 1'b0; flush_all = 1'b0; update_mispredict = 1'b0;
    reset_n = 1'b0;
    #2;
    chk("in_reset.hit",   longint'(pred_hit),   0);
    chk("in_reset.taken", longint'(pred_taken), 0);
    chk("in_reset.next",  longint'(next_PC),    longint'(16'h0124));
    do_reset();

    for (int i = 0; i < 25; i++)
      run_cycle(tbl[i].pc, tbl[i].uv, tbl[i].upc, tbl[i].ut, tbl[i].utgt, tbl[i].fl, 1'b0,
                1'b1, tbl[i].eh, tbl[i].et, tbl[i].en, $sformatf("vec%0d", i));

    // Async reset in mid-cycle clears the live entry at once and drops the pending update.
    PC = 16'h0040; update_valid = 1'b1; update_pc = 16'h0050;
    update_taken = 1'b1; update_target = 16'h0555;
    #1;
    chk("pre_reset.hit", longint'(pred_hit), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset.hit",  longint'(pred_hit), 0);
    chk("async_reset.next", longint'(next_PC),  longint'(16'h0041));
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    update_valid = 1'b0;
    run_cycle(16'h0050, 0, 16'h0, 0, 16'h0, 0, 0, 1'b1, 0, 0, 16'h0051, "reset_drop_upd");

`ifdef BP_STATS_EN
    do_reset();
    run_cycle(16'h0123, 1, 16'h0123, 1, 16'h0200, 0, 0, 1'b0, 0, 0, 0, "st_alloc");
    for (int i = 0; i < 5; i++)
      run_cycle(16'h0123, (i == 1 || i == 3), 16'h0700, 0, 16'h0, 0, 1, 1'b0, 0, 0, 0, "st_hit");
    chk("stat_lookups",     longint'(stat_lookups),     5);
    chk("stat_mispredicts", longint'(stat_mispredicts), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("stat_lookups_rst",     longint'(stat_lookups),     0);
    chk("stat_mispredicts_rst", longint'(stat_mispredicts), 0);
    m_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
`endif

    // Randomized traffic over a small PC pool so entries alias and saturate often.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rpc  = ($urandom_range(0, 15) == 0) ? 16'($urandom) :
             16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      rupc = 16'(($urandom_range(0, 3) << 8) | $urandom_range(0, 7));
      run_cycle(rpc, $urandom_range(0, 2) != 0, rupc, $urandom_range(0, 1) == 1,
                16'($urandom), $urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                1'b0, 0, 0, 0, $sformatf("rnd%0d", n));
    end
    m_lookup(16'hFFFF, rh, rt, rn);
    if (!rh) run_cycle(16'hFFFF, 0, 16'h0, 0, 16'h0, 0, 0, 1'b1, 0, 0, 16'h0000, "wrap_end");
`ifdef BP_STATS_EN
    chk("rnd_stat_lookups",     longint'(stat_lookups),     longint'(m_lookups));
    chk("rnd_stat_mispredicts", longint'(stat_mispredicts), longint'(m_misp));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
